// File: rtl/red_pitaya_lock_pkg.sv
// Shared definitions for the relock supervisor: state encoding, default widths
// and a small saturating counter helper.
package red_pitaya_lock_pkg;

  localparam int DW_DEF       = 14;
  localparam int CNT_BITS_DEF = 16;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_CLEAR    = 3'd2,
    ST_SWEEP    = 3'd3,
    ST_ACQUIRE  = 3'd4
  } relock_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/red_pitaya_relock_ctrl_if.sv
// Control and settings bundle between the relock FSM and the triangle sweep generator.
interface red_pitaya_relock_ctrl_if
  import red_pitaya_lock_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) ();

  logic                 en;
  logic                 load;
  logic                 freeze;
  logic signed [DW-1:0] sweep_min;
  logic signed [DW-1:0] sweep_max;
  logic [DW-2:0]        sweep_step;
  logic [CNT_BITS-1:0]  sweep_div;
  logic signed [DW-1:0] sweep;

  modport master (
    output en, load, freeze, sweep_min, sweep_max, sweep_step, sweep_div,
    input  sweep
  );

  modport slave (
    input  en, load, freeze, sweep_min, sweep_max, sweep_step, sweep_div,
    output sweep
  );

endinterface

// File: rtl/red_pitaya_sweep_gen.sv
// Triangle sweep generator: clamped load, divided stepping, bounce at min/max.
// en=0 returns the output to zero; freeze holds value, direction and divider.
module red_pitaya_sweep_gen
  import red_pitaya_lock_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  red_pitaya_relock_ctrl_if.slave sw
);

  logic signed [DW-1:0] sweep_q, sweep_d;
  logic                 dir_dn_q, dir_dn_d;
  logic [CNT_BITS-1:0]  div_q, div_d;
  logic signed [DW:0]   step_w, nxt_w, min_w, max_w;

  function automatic logic signed [DW-1:0] clamp_sweep(
    input logic signed [DW-1:0] v,
    input logic signed [DW-1:0] lo,
    input logic signed [DW-1:0] hi
  );
    if (lo >= hi) return lo;
    if (v < lo)   return lo;
    if (v > hi)   return hi;
    return v;
  endfunction

  always_comb begin
    min_w    = (DW+1)'(sw.sweep_min);
    max_w    = (DW+1)'(sw.sweep_max);
    step_w   = $signed({2'b00, sw.sweep_step});
    // One extra bit of headroom so overshoot is detected instead of wrapping
    nxt_w    = dir_dn_q ? (DW+1)'(sweep_q) - step_w : (DW+1)'(sweep_q) + step_w;
    sweep_d  = sweep_q;
    dir_dn_d = dir_dn_q;
    div_d    = div_q;
    if (!sw.en) begin
      sweep_d  = '0;
      dir_dn_d = 1'b0;
      div_d    = '0;
    end else if (sw.load) begin
      sweep_d  = clamp_sweep(sweep_q, sw.sweep_min, sw.sweep_max);
      dir_dn_d = 1'b0;
      div_d    = '0;
    end else if (!sw.freeze) begin
      if (sw.sweep_min >= sw.sweep_max) begin
        sweep_d = sw.sweep_min;
        div_d   = '0;
      end else if (div_q >= sw.sweep_div) begin
        div_d = '0;
        if (nxt_w > max_w) begin
          sweep_d  = sw.sweep_max;
          dir_dn_d = 1'b1;
        end else if (nxt_w < min_w) begin
          sweep_d  = sw.sweep_min;
          dir_dn_d = 1'b0;
        end else begin
          sweep_d  = nxt_w[DW-1:0];
        end
      end else begin
        div_d = div_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sweep_q  <= '0;
      dir_dn_q <= 1'b0;
      div_q    <= '0;
    end else begin
      sweep_q  <= sweep_d;
      dir_dn_q <= dir_dn_d;
      div_q    <= div_d;
    end
  end

  assign sw.sweep = sweep_q;

endmodule

// File: rtl/red_pitaya_relock_ctrl.sv
// Relock supervisor: watches PID rails and a lock monitor, and on loss of lock
// resets the integrator and sweeps the actuator offset until lock is reacquired.
module red_pitaya_relock_ctrl
  import red_pitaya_lock_pkg::*;
#(
  parameter int CNT_BITS = CNT_BITS_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  input  logic signed [DW-1:0] pid_dat_i,
  input  logic signed [DW-1:0] mon_dat_i,
  input  logic signed [DW-1:0] set_rail_lo_i,
  input  logic signed [DW-1:0] set_rail_hi_i,
  input  logic signed [DW-1:0] set_win_lo_i,
  input  logic signed [DW-1:0] set_win_hi_i,
  input  logic [CNT_BITS-1:0]  set_loss_cnt_i,
  input  logic [CNT_BITS-1:0]  set_acq_cnt_i,
  input  logic [CNT_BITS-1:0]  set_sweep_div_i,
  input  logic signed [DW-1:0] set_sweep_min_i,
  input  logic signed [DW-1:0] set_sweep_max_i,
  input  logic [DW-2:0]        set_sweep_step_i,
  output logic [1:0]           railed_o,
  output logic                 hold_o,
  output logic                 int_rst_o,
  output logic signed [DW-1:0] sweep_o,
  output logic                 locked_o,
  output logic [2:0]           state_o,
  output logic [15:0]          relock_cnt_o
);

  relock_state_e       state_q, state_d;
  logic [1:0]          railed_q;
  logic                in_win_q;
  logic                bad;
  logic [CNT_BITS-1:0] loss_q, acq_q;
  logic [15:0]         relock_q;

  red_pitaya_relock_ctrl_if #(.DW(DW), .CNT_BITS(CNT_BITS)) sw_if ();

  // Input qualification stage: every FSM decision sees these registered flags
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      railed_q <= '0;
      in_win_q <= 1'b0;
    end else begin
      railed_q <= {pid_dat_i >= set_rail_hi_i, pid_dat_i <= set_rail_lo_i};
      in_win_q <= (mon_dat_i >= set_win_lo_i) && (mon_dat_i <= set_win_hi_i);
    end
  end

  assign bad = !in_win_q || (railed_q != 2'b00);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_DISABLED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: state_d = ST_LOCKED;
      ST_LOCKED:   if (bad && (loss_q >= set_loss_cnt_i)) state_d = ST_CLEAR;
      ST_CLEAR:    state_d = ST_SWEEP;
      ST_SWEEP:    if (in_win_q) state_d = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (!in_win_q)                    state_d = ST_SWEEP;
        else if (acq_q >= set_acq_cnt_i)  state_d = ST_LOCKED;
      end
      default:     state_d = ST_DISABLED;
    endcase
    if (!enable_i) state_d = ST_DISABLED;
  end

  // Loss/acquire counters restart whenever their state is entered or left
  always_ff @(posedge clk_i) begin
    if (!rstn_i || (state_d == ST_DISABLED)) begin
      loss_q   <= '0;
      acq_q    <= '0;
      relock_q <= '0;
    end else begin
      loss_q <= (state_q == ST_LOCKED && state_d == ST_LOCKED && bad) ?
                loss_q + CNT_BITS'(1) : '0;
      acq_q  <= (state_q == ST_ACQUIRE && state_d == ST_ACQUIRE) ?
                acq_q + CNT_BITS'(1) : '0;
      if (state_d == ST_CLEAR) relock_q <= sat_inc16(relock_q);
    end
  end

  // The sweep only advances on cycles that stay in SWEEP, so it freezes on the
  // very edge where the monitor reports the window was reached.
  assign sw_if.en         = (state_d != ST_DISABLED);
  assign sw_if.load       = (state_q == ST_CLEAR);
  assign sw_if.freeze     = !(state_q == ST_SWEEP && state_d == ST_SWEEP);
  assign sw_if.sweep_min  = set_sweep_min_i;
  assign sw_if.sweep_max  = set_sweep_max_i;
  assign sw_if.sweep_step = set_sweep_step_i;
  assign sw_if.sweep_div  = set_sweep_div_i;

  red_pitaya_sweep_gen #(.DW(DW), .CNT_BITS(CNT_BITS)) u_sweep_gen (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .sw     (sw_if)
  );

  assign railed_o     = railed_q;
  assign state_o      = state_q;
  assign locked_o     = (state_q == ST_LOCKED);
  assign hold_o       = (state_q == ST_CLEAR) || (state_q == ST_SWEEP);
  assign int_rst_o    = (state_q == ST_CLEAR) || (state_q == ST_SWEEP);
  assign sweep_o      = sw_if.sweep;
  assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_red_pitaya_relock_ctrl.sv
// Bench for the relock supervisor: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural model.
module tb_red_pitaya_relock_ctrl;
  localparam int DW       = 14;
  localparam int CNT_BITS = 16;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic signed [DW-1:0] pid, mon, rail_lo, rail_hi, win_lo, win_hi;
  logic [CNT_BITS-1:0]  loss_cnt, acq_cnt;
  logic [1:0]           railed;
  logic                 hold, int_rst, locked;
  logic signed [DW-1:0] sweep;
  logic [2:0]           state;
  logic [15:0]          relock_cnt;

  red_pitaya_relock_ctrl_if #(.DW(DW), .CNT_BITS(CNT_BITS)) cfg ();

  red_pitaya_relock_ctrl #(.CNT_BITS(CNT_BITS), .DW(DW)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .enable_i         (cfg.en),
    .pid_dat_i        (pid),
    .mon_dat_i        (mon),
    .set_rail_lo_i    (rail_lo),
    .set_rail_hi_i    (rail_hi),
    .set_win_lo_i     (win_lo),
    .set_win_hi_i     (win_hi),
    .set_loss_cnt_i   (loss_cnt),
    .set_acq_cnt_i    (acq_cnt),
    .set_sweep_div_i  (cfg.sweep_div),
    .set_sweep_min_i  (cfg.sweep_min),
    .set_sweep_max_i  (cfg.sweep_max),
    .set_sweep_step_i (cfg.sweep_step),
    .railed_o         (railed),
    .hold_o           (hold),
    .int_rst_o        (int_rst),
    .sweep_o          (sweep),
    .locked_o         (locked),
    .state_o          (state),
    .relock_cnt_o     (relock_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit chk_on = 1'b0;

  // Behavioural model: state as plain ints (0 off, 1 locked, 2 clear, 3 sweep, 4 acquire)
  int m_st = 0, m_rail = 0, m_win = 0, m_loss = 0, m_acq = 0, m_rel = 0;
  int m_sw = 0, m_div = 0;
  bit m_up = 1'b1;

  always @(posedge clk) begin : model
    int st, nx, lo, hi;
    bit bad;
    if (!rstn) begin
      m_st = 0; m_rail = 0; m_win = 0; m_loss = 0; m_acq = 0; m_rel = 0;
      m_sw = 0; m_div = 0; m_up = 1'b1;
    end else begin
      lo  = cfg.sweep_min;
      hi  = cfg.sweep_max;
      bad = (m_win == 0) || (m_rail != 0);
      if (!cfg.en) st = 0;
      else case (m_st)
        1:       st = (bad && m_loss >= int'(loss_cnt)) ? 2 : 1;
        2:       st = 3;
        3:       st = m_win ? 4 : 3;
        4:       st = (m_win == 0) ? 3 : ((m_acq >= int'(acq_cnt)) ? 1 : 4);
        default: st = 1;
      endcase
      if (st == 0) begin
        m_loss = 0; m_acq = 0; m_rel = 0; m_sw = 0; m_div = 0; m_up = 1'b1;
      end else begin
        m_loss = (m_st == 1 && st == 1 && bad) ? m_loss + 1 : 0;
        m_acq  = (m_st == 4 && st == 4) ? m_acq + 1 : 0;
        if (st == 2 && m_rel < 65535) m_rel++;
        if (m_st == 2) begin
          if (lo >= hi)      m_sw = lo;
          else if (m_sw < lo) m_sw = lo;
          else if (m_sw > hi) m_sw = hi;
          m_up = 1'b1; m_div = 0;
        end else if (m_st == 3 && st == 3) begin
          if (lo >= hi) begin
            m_sw = lo; m_div = 0;
          end else if (m_div >= int'(cfg.sweep_div)) begin
            m_div = 0;
            nx = m_up ? m_sw + int'(cfg.sweep_step) : m_sw - int'(cfg.sweep_step);
            if (nx > hi)      begin m_sw = hi; m_up = 1'b0; end
            else if (nx < lo) begin m_sw = lo; m_up = 1'b1; end
            else              m_sw = nx;
          end else m_div++;
        end
      end
      m_rail = ((pid >= rail_hi) ? 2 : 0) | ((pid <= rail_lo) ? 1 : 0);
      m_win  = (mon >= win_lo && mon <= win_hi) ? 1 : 0;
      m_st   = st;
    end
  end

  always @(negedge clk) begin : compare
    bit eh;
    if (chk_on) begin
      eh = (m_st == 2) || (m_st == 3);
      vectors++;
      if (state !== 3'(m_st) || locked !== (m_st == 1) || hold !== eh || int_rst !== eh ||
          railed !== 2'(m_rail) || sweep !== DW'(m_sw) || relock_cnt !== 16'(m_rel)) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t: dut st=%0d lk=%0b hd=%0b ir=%0b rl=%0d sw=%0d rc=%0d, model st=%0d rl=%0d sw=%0d rc=%0d",
                 $time, state, locked, hold, int_rst, railed, sweep, relock_cnt, m_st, m_rail, m_sw, m_rel);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state) != s && n < budget) begin tick(); n++; end
    expect_val(name, int'(state), s);
  endtask

  int sweep_tbl[6] = '{150, 200, 50, -100, -200, -50};
  int n, n_acq, p_win;

  initial begin
    rstn = 1'b0; cfg.en = 1'b0; cfg.load = 1'b0; cfg.freeze = 1'b0;
    pid = '0; mon = '0; rail_lo = -14'sd8000; rail_hi = 14'sd8000;
    win_lo = -14'sd100; win_hi = 14'sd100; loss_cnt = 16'd9; acq_cnt = 16'd4;
    cfg.sweep_min = -14'sd200; cfg.sweep_max = 14'sd200; cfg.sweep_step = 13'd150;
    cfg.sweep_div = '0;
    tick();
    chk_on = 1'b1;
    expect_val("rst_state", int'(state), 0);
    expect_val("rst_sweep", int'(sweep), 0);
    expect_val("rst_railed", int'(railed), 0);
    expect_val("rst_hold", int'(hold), 0);

    rstn = 1'b1; cfg.en = 1'b1;
    tick(); tick(); tick();
    expect_val("locked_state", int'(state), 1);
    expect_val("locked_flag", int'(locked), 1);

    // Monitor out of window for ten cycles
    mon = 14'sd500;
    for (int i = 0; i < 10; i++) tick();
    expect_val("loss_10th_still_locked", int'(state), 1);
    tick();
    expect_val("clear_state", int'(state), 2);
    expect_val("clear_int_rst", int'(int_rst), 1);
    expect_val("clear_locked", int'(locked), 0);
    expect_val("clear_relock_cnt", int'(relock_cnt), 1);
    tick();
    expect_val("sweep_state", int'(state), 3);
    expect_val("sweep_start", int'(sweep), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_val($sformatf("sweep_seq%0d", i), int'(sweep), sweep_tbl[i]);
    end

    // Window reached: acquire for three good cycles, then drop out
    mon = '0;
    tick();
    expect_val("sweep_last_step", int'(sweep), 100);
    tick();
    expect_val("acq_state", int'(state), 4);
    expect_val("acq_frozen", int'(sweep), 100);
    expect_val("acq_hold", int'(hold), 0);
    tick(); tick();
    mon = 14'sd500;
    tick();
    expect_val("acq_still", int'(state), 4);
    tick();
    expect_val("acq_back_to_sweep", int'(state), 3);
    expect_val("acq_back_sweep_val", int'(sweep), 100);

    // Window reached again: five good acquire cycles then lock
    mon = '0;
    n_acq = 0;
    for (int i = 0; i < 40 && state != 3'd1; i++) begin
      tick();
      if (state == 3'd4) n_acq++;
    end
    expect_val("relock_locked", int'(locked), 1);
    expect_val("relock_acq_cycles", n_acq, 5);
    expect_val("relock_sweep_frozen", int'(sweep), 200);

    // Upper rail hit while locked
    pid = 14'sd8000;
    tick();
    expect_val("railed_hi", int'(railed), 2);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (state == 3'd2) break;
      n++;
    end
    expect_val("rail_loss_cycles", n, 10);
    expect_val("rail_relock_cnt", int'(relock_cnt), 2);
    pid = '0;

    // Reset while sweeping
    wait_state(3, 5, "pre_reset_sweep");
    tick();
    rstn = 1'b0;
    tick();
    expect_val("rst_mid_sweep_state", int'(state), 0);
    expect_val("rst_mid_sweep_sweep", int'(sweep), 0);
    expect_val("rst_mid_sweep_irst", int'(int_rst), 0);
    expect_val("rst_mid_sweep_relock", int'(relock_cnt), 0);
    rstn = 1'b1;
    loss_cnt = '0;
    mon = '0;
    wait_state(1, 10, "relock_after_rst");
    mon = 14'sd500;
    wait_state(3, 10, "second_sweep");
    tick(); tick();
    mon = '0;
    wait_state(4, 20, "second_acquire");
    cfg.en = 1'b0;
    tick();
    expect_val("dis_mid_acq_state", int'(state), 0);
    expect_val("dis_mid_acq_sweep", int'(sweep), 0);
    expect_val("dis_mid_acq_hold", int'(hold), 0);

    // Randomized phase
    p_win = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) begin
        loss_cnt       = CNT_BITS'($urandom_range(0, 6));
        acq_cnt        = CNT_BITS'($urandom_range(0, 5));
        cfg.sweep_div  = CNT_BITS'($urandom_range(0, 3));
        cfg.sweep_step = 13'($urandom_range(0, 300));
        win_lo         = DW'(-int'($urandom_range(40, 150)));
        win_hi         = DW'(int'($urandom_range(40, 150)));
        rail_lo        = DW'(-int'($urandom_range(3000, 8000)));
        rail_hi        = DW'(int'($urandom_range(3000, 8000)));
        if ($urandom_range(0, 9) == 0) begin
          cfg.sweep_min = DW'(int'($urandom_range(0, 300)));
          cfg.sweep_max = DW'(int'($urandom_range(0, 300)) - 300);
        end else begin
          cfg.sweep_min = DW'(-int'($urandom_range(1, 8191)));
          cfg.sweep_max = DW'(int'($urandom_range(0, 8191)));
        end
      end
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       p_win = 10;
          1:       p_win = 50;
          default: p_win = 95;
        endcase
      end
      case ($urandom_range(0, 19))
        0:       mon = win_lo;
        1:       mon = win_hi;
        default: mon = ($urandom_range(0, 99) < p_win) ? DW'(int'($urandom_range(0, 80)) - 40)
                                                      : DW'(int'($urandom_range(200, 8000)) *
                                                            (($urandom_range(0, 1) == 1) ? 1 : -1));
      endcase
      case ($urandom_range(0, 39))
        0:       pid = rail_hi;
        1:       pid = rail_lo;
        2:       pid = DW'(int'($urandom_range(0, 16383)) - 8192);
        default: pid = DW'(int'($urandom_range(0, 2000)) - 1000);
      endcase
      cfg.en = ($urandom_range(0, 149) != 0);
      rstn   = ($urandom_range(0, 399) != 0);
      tick();
    end
    rstn = 1'b1;
    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/red_pitaya_relock_ctrl.md
RED_PITAYA_RELOCK_CTRL -- requirements
Module: red_pitaya_relock_ctrl

Interface
REQ-001 SHALL have parameter CNT_BITS, default 16, width of the loss, acquire and divider counters and their settings.
REQ-002 SHALL have parameter DW, default 14, signed data width of monitored signals and sweep output.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rstn_i, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1, relock supervisor enable.
REQ-006 SHALL have port pid_dat_i, input, DW signed, PID output under supervision.
REQ-007 SHALL have port mon_dat_i, input, DW signed, lock-quality monitor signal.
REQ-008 SHALL have ports set_rail_lo_i and set_rail_hi_i, input, DW signed each, PID rail thresholds.
REQ-009 SHALL have ports set_win_lo_i and set_win_hi_i, input, DW signed each, lock window bounds (inclusive).
REQ-010 SHALL have ports set_loss_cnt_i, set_acq_cnt_i and set_sweep_div_i, input, CNT_BITS unsigned each.
REQ-011 SHALL have ports set_sweep_min_i, set_sweep_max_i and set_sweep_step_i, input, DW signed, DW signed and DW-1 unsigned respectively.
REQ-012 SHALL have port railed_o, output, 2: bit0 lower rail, bit1 upper rail; drives PID railed_i.
REQ-013 SHALL have ports hold_o and int_rst_o, output, 1 each; drive PID hold_i and int_rst_i.
REQ-014 SHALL have port sweep_o, output, DW signed, offset added to the actuator path.
REQ-015 SHALL have ports locked_o (1), state_o (3) and relock_cnt_o (16), output, status.

Function
REQ-016 SHALL register railed_o[0] = (pid_dat_i <= set_rail_lo_i) and railed_o[1] = (pid_dat_i >= set_rail_hi_i), 1-cycle latency, in every state.
REQ-017 SHALL register in_win = (set_win_lo_i <= mon_dat_i <= set_win_hi_i); all FSM decisions use registered in_win and railed_o.
REQ-018 SHALL implement states DISABLED=0, LOCKED=1, CLEAR=2, SWEEP=3, ACQUIRE=4 on state_o; codes 5-7 unused and recover to DISABLED.
REQ-019 SHALL go to DISABLED on the cycle after enable_i=0 from any state; this overrides every other transition.
REQ-020 DISABLED: all outputs except railed_o are 0, counters cleared; enable_i=1 -> LOCKED.
REQ-021 LOCKED: locked_o=1, hold_o=0, int_rst_o=0, sweep_o holds its value; loss counter increments when in_win=0 or railed_o!=0, clears otherwise; bad cycle with counter >= set_loss_cnt_i -> CLEAR (set_loss_cnt_i=0: first bad cycle).
REQ-022 CLEAR: exactly one cycle, hold_o=1, int_rst_o=1, locked_o=0, relock_cnt_o incremented (saturates at 16'hFFFF); -> SWEEP.
REQ-023 SWEEP: hold_o=1, int_rst_o=1; sweep_o starts from its current value clamped into [min,max]; updates by +/-step once per (set_sweep_div_i+1) cycles, direction initially up.
REQ-024 Sweep arithmetic in DW+1 bits; result > max -> sweep_o=max, direction down; result < min -> sweep_o=min, direction up; no wrap-around.
REQ-025 If set_sweep_min_i >= set_sweep_max_i, sweep_o SHALL be held at set_sweep_min_i.
REQ-026 SWEEP with in_win=1 -> ACQUIRE; sweep_o frozen, hold_o=0, int_rst_o=0.
REQ-027 ACQUIRE: acquire counter increments per in_win=1 cycle; in_win=0 -> SWEEP (direction preserved); counter >= set_acq_cnt_i with in_win=1 -> LOCKED.
REQ-028 On enable_i=0, sweep_o SHALL return to 0 on the next cycle.

Reset
REQ-029 rstn_i=0 at a clock edge SHALL force DISABLED, all outputs 0, all counters 0, sweep direction up, including mid-sweep or mid-acquire.

Structure
REQ-030 State encodings and DW default SHALL live in shared package red_pitaya_lock_pkg.
REQ-031 Triangle generator (divider, clamp, direction) SHALL be sub-module red_pitaya_sweep_gen with enable, load and freeze inputs.

Verification
REQ-032 enable=1, mon=0 in window [-100,100], loss_cnt=9; mon=500 for 10 cycles -> CLEAR on the 10th bad cycle, int_rst_o 1, relock_cnt_o=1.
REQ-033 pid_dat=8000, rail_hi=8000 -> railed_o=2'b10 one cycle later, loss counting starts in LOCKED.
REQ-034 SWEEP, min=-200, max=200, step=150, div=0, start 0 -> sweep_o 150,200,50,-100,-200,-50.
REQ-035 ACQUIRE, acq_cnt=4, in_win high 3 cycles then low -> back to SWEEP; high 5 cycles -> LOCKED, locked_o=1, sweep_o frozen.
REQ-036 rstn_i=0 mid-SWEEP and enable_i=0 mid-ACQUIRE -> state_o=0, sweep_o=0, hold_o=int_rst_o=0 next cycle.
